// File: rtl/layer_sequencer_if.sv
// Handshake and datapath-control bundle between a layer_sequencer and its environment.
interface layer_sequencer_if;
    logic       start;
    logic       src_valid;
    logic       src_ready;
    logic       pix_valid;
    logic       vs_out;
    logic       mode_out;
    logic       param_we;
    logic [6:0] param_addr;
    logic       win_valid;
    logic       busy;
    logic       frame_done;
    logic [9:0] win_count;
    logic       err;
    logic       timeout;

    // sequencer side
    modport slave (
        input  start, src_valid, win_valid,
        output src_ready, pix_valid, vs_out, mode_out, param_we, param_addr,
               busy, frame_done, win_count, err, timeout
    );

    // environment / controller side
    modport master (
        output start, src_valid, win_valid,
        input  src_ready, pix_valid, vs_out, mode_out, param_we, param_addr,
               busy, frame_done, win_count, err, timeout
    );
endinterface

// File: rtl/layer_sequencer.sv
// Per-layer control: parameter load, vsync, paced pixel streaming, drain, window-count check.
// Optional stall watchdog enabled by defining WATCHDOG_EN.
module layer_sequencer #(
    parameter int unsigned FM_WIDTH    = 56,
    parameter int unsigned PERIOD      = 8,
    parameter int unsigned PARAM_WORDS = 64,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.slave   bus
);
    localparam int unsigned NPIX      = FM_WIDTH * FM_WIDTH;
    localparam int unsigned NWIN      = (FM_WIDTH / 2) * (FM_WIDTH / 2);
    localparam int unsigned DRAIN_CYC = 2 * PERIOD;
    localparam int unsigned CNT_MAX   = (PARAM_WORDS > DRAIN_CYC) ? PARAM_WORDS : DRAIN_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX);
    localparam int unsigned GAP_W     = $clog2(PERIOD);
    localparam int unsigned PIX_W     = $clog2(NPIX);
    localparam int unsigned WC_W      = 10;

    if (FM_WIDTH < 4 || (FM_WIDTH % 2) != 0 || PERIOD < 3 ||
        PARAM_WORDS < 2 || PARAM_WORDS > 128 || TIMEOUT < 2) begin : g_param_check
        $error("layer_sequencer: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VSYNC, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [WC_W-1:0]   win_q, win_d;
    logic              err_q, err_d;
    logic              vs_q, vs_d, mode_q, mode_d, we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [6:0]        addr_q, addr_d;
    logic              src_ready_c, accept_c;

`ifdef WATCHDOG_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT);
    logic [TO_W-1:0]   stall_q, stall_d;
    logic              to_q, to_d;
`endif

    // Ready is a pure function of the gap counter so the first pixel of a frame is never delayed.
    assign src_ready_c = !rst && (state_q == S_STREAM) && (gap_q == GAP_W'(PERIOD - 1));
    assign accept_c    = src_ready_c & bus.src_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        pix_d   = pix_q;
        win_d   = win_q;
        err_d   = err_q;
`ifdef WATCHDOG_EN
        stall_d = stall_q;
        to_d    = to_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef WATCHDOG_EN
                    to_d    = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (cnt_q == CNT_W'(PARAM_WORDS - 1)) begin
                    state_d = S_VSYNC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_VSYNC: begin
                state_d = S_STREAM;
                gap_d   = GAP_W'(PERIOD - 1);
                pix_d   = '0;
                win_d   = '0;
`ifdef WATCHDOG_EN
                stall_d = '0;
`endif
            end
            S_STREAM: begin
                if (accept_c) begin
                    gap_d = '0;
`ifdef WATCHDOG_EN
                    stall_d = '0;
`endif
                    if (pix_q == PIX_W'(NPIX - 1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end else begin
                    if (gap_q != GAP_W'(PERIOD - 1)) gap_d = gap_q + GAP_W'(1);
`ifdef WATCHDOG_EN
                    if (stall_q == TO_W'(TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        to_d    = 1'b1;
                    end else begin
                        stall_d = stall_q + TO_W'(1);
                    end
`endif
                end
            end
            S_DRAIN: begin
                if (cnt_q == CNT_W'(DRAIN_CYC - 1)) state_d = S_DONE;
                else                                 cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Windows only count while the datapath can legitimately produce them.
        if ((state_q == S_STREAM || state_q == S_DRAIN) && bus.win_valid && (win_q != '1))
            win_d = win_q + WC_W'(1);

        // Judge the frame as DONE is entered so err is already valid alongside frame_done.
        if (state_q == S_DRAIN && state_d == S_DONE)
            err_d = (32'(win_d) != NWIN);

        busy_d = (state_d != S_IDLE);
        mode_d = (state_d inside {S_VSYNC, S_STREAM, S_DRAIN, S_DONE});
        vs_d   = (state_d == S_VSYNC);
        we_d   = (state_d == S_LOAD);
        addr_d = we_d ? 7'(cnt_d) : 7'd0;
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            pix_q   <= '0;
            win_q   <= '0;
            err_q   <= 1'b0;
            vs_q    <= 1'b0;
            mode_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef WATCHDOG_EN
            stall_q <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pix_q   <= pix_d;
            win_q   <= win_d;
            err_q   <= err_d;
            vs_q    <= vs_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef WATCHDOG_EN
            stall_q <= stall_d;
            to_q    <= to_d;
`endif
        end
    end

    assign bus.src_ready  = src_ready_c;
    assign bus.pix_valid  = accept_c;
    assign bus.vs_out     = vs_q;
    assign bus.mode_out   = mode_q;
    assign bus.param_we   = we_q;
    assign bus.param_addr = addr_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.win_count  = win_q;
    assign bus.err        = err_q;
`ifdef WATCHDOG_EN
    assign bus.timeout    = to_q;
`else
    assign bus.timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer against a cycle-timeline reference model.
module tb_layer_sequencer;
    localparam int FM   = 4;
    localparam int P    = 8;
    localparam int PW   = 4;
    localparam int TO   = 64;
    localparam int NPIX = FM * FM;
    localparam int NWIN = (FM / 2) * (FM / 2);

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    layer_sequencer_if bus ();

    layer_sequencer #(
        .FM_WIDTH(FM), .PERIOD(P), .PARAM_WORDS(PW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Packs every output: ready,pix,vs,mode,we,addr[7],busy,done,wc[10],err,timeout
    function automatic logic [25:0] outs();
        return {bus.src_ready, bus.pix_valid, bus.vs_out, bus.mode_out, bus.param_we,
                bus.param_addr, bus.busy, bus.frame_done, bus.win_count, bus.err, bus.timeout};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [25:0] o;
        rst = 1'b1; bus.start = 1'b1; bus.src_valid = 1'b1; bus.win_valid = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        o = outs();
        total++;
        if (o !== 26'd0) begin
            bad++; $display("FAIL reset_hold: outputs=%h required=0", o);
        end
        next_cycle();
        rst = 1'b0; bus.start = 1'b0; bus.src_valid = 1'b0; bus.win_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        o = outs();
        total++;
        if (o !== 26'd0) begin
            bad++; $display("FAIL reset_after: outputs=%h required=0", o);
        end
    endtask

    // One full layer; mode 0 = src_valid held, 1 = random pct, 2 = 20-cycle drop after 3rd accept.
    task automatic test_frame(input int mode, input int nwin, input int pct);
        int n_acc = 0, last_acc = -1000, t_last = 0, wc = 0, drop_start = -1;
        bit finished = 0;
        bit in_stream, in_drain, is_done, alive;
        logic sv, wv;
        logic [25:0] exp_o, got, mask;
        bus.start = 1'b1;
        for (int t = 1; t <= 1500 && !finished; t++) begin
            next_cycle();
            in_stream = (t >= PW + 2) && (n_acc < NPIX);
            in_drain  = (n_acc == NPIX) && (t <= t_last + 2 * P);
            is_done   = (n_acc == NPIX) && (t == t_last + 2 * P + 1);
            alive     = (n_acc < NPIX) || (t <= t_last + 2 * P + 1);
            case (mode)
                0:       sv = 1'b1;
                1:       sv = ($urandom_range(0, 99) < pct);
                default: sv = !(drop_start >= 0 && t >= drop_start && t < drop_start + 20);
            endcase
            wv = is_done || (n_acc >= 1 && n_acc <= nwin && t == last_acc + 2);
            bus.start     = in_stream && ($urandom_range(0, 7) == 0);
            bus.src_valid = sv;
            bus.win_valid = wv;
            exp_o = {in_stream && (t - last_acc >= P),
                     in_stream && (t - last_acc >= P) && sv,
                     t == PW + 1,
                     (t >= PW + 1) && alive,
                     t <= PW,
                     (t <= PW) ? 7'(t - 1) : 7'd0,
                     alive,
                     is_done,
                     10'(wc),
                     (n_acc == NPIX && t > t_last + 2 * P) ? (wc != NWIN) : 1'b0,
                     1'b0};
            mask = (t >= PW + 2) ? '1 : ~(26'h3ff << 2);
            @(negedge clk);
            got = outs();
            total++;
            if ((got & mask) !== (exp_o & mask)) begin
                bad++;
                $display("FAIL frame_m%0d_t%0d: outputs=%h required=%h (mask %h)", mode, t, got, exp_o, mask);
            end
            if (exp_o[24]) begin
                n_acc++;
                last_acc = t;
                if (n_acc == NPIX) t_last = t;
                if (n_acc == 3 && mode == 2) drop_start = t + 1;
            end
            if (wv && (in_stream || in_drain) && wc < 1023) wc++;
            if (n_acc == NPIX && t == t_last + 2 * P + 2) finished = 1;
        end
        total++;
        if (!finished) begin
            bad++; $display("FAIL frame_m%0d_budget: accepts=%0d required=%0d", mode, n_acc, NPIX);
        end
        bus.start = 1'b0; bus.src_valid = 1'b0; bus.win_valid = 1'b0;
    endtask

    task automatic test_err();
        test_frame(0, 3, 0);
        repeat (5) next_cycle();
        @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL err_sticky: err=%b busy=%b required err=1 busy=0", bus.err, bus.busy);
        end
        test_frame(0, 4, 0);
    endtask

    task automatic test_reset_midframe();
        int seen = 0;
        logic [25:0] o;
        bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0; bus.src_valid = 1'b1;
        for (int i = 0; i < 300 && seen < 7; i++) begin
            @(negedge clk);
            if (bus.pix_valid) seen++;
            if (seen < 7) next_cycle();
        end
        total++;
        if (seen != 7) begin
            bad++; $display("FAIL rst_mid_accepts: seen=%0d required=7", seen);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (bus.src_ready !== 1'b0 || bus.pix_valid !== 1'b0) begin
            bad++; $display("FAIL rst_mid_during: ready=%b pix=%b required 0 0", bus.src_ready, bus.pix_valid);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        o = outs();
        total++;
        if (o !== 26'd0) begin
            bad++; $display("FAIL rst_mid_after: outputs=%h required=0", o);
        end
        bus.src_valid = 1'b0;
        next_cycle();
        test_frame(0, 4, 0);
    endtask

    task automatic test_watchdog();
        bit done_seen = 0;
        bus.start = 1'b1;
        next_cycle();
        bus.start = 1'b0; bus.src_valid = 1'b0;
`ifdef WATCHDOG_EN
        for (int t = 1; t <= 200; t++) begin
            @(negedge clk);
            if (bus.frame_done) done_seen = 1;
            if (t == PW + 1 + TO) begin
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++; $display("FAIL wd_before: busy=%b required=1", bus.busy);
                end
            end
            if (t == PW + 2 + TO) begin
                total++;
                if (bus.busy !== 1'b0 || bus.timeout !== 1'b1) begin
                    bad++; $display("FAIL wd_abort: busy=%b timeout=%b required 0 1", bus.busy, bus.timeout);
                end
            end
            next_cycle();
        end
        total++;
        if (done_seen || bus.timeout !== 1'b1) begin
            bad++; $display("FAIL wd_after: done_seen=%b timeout=%b required 0 1", done_seen, bus.timeout);
        end
`else
        repeat (150) next_cycle();
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1 || bus.timeout !== 1'b0) begin
            bad++; $display("FAIL nowd_wait: busy=%b timeout=%b required 1 0", bus.busy, bus.timeout);
        end
        next_cycle();
        bus.src_valid = 1'b1;
        for (int i = 0; i < 400 && !done_seen; i++) begin
            @(negedge clk);
            if (bus.frame_done) done_seen = 1;
            next_cycle();
        end
        bus.src_valid = 1'b0;
        @(negedge clk);
        total++;
        if (!done_seen || bus.busy !== 1'b0) begin
            bad++; $display("FAIL nowd_finish: done_seen=%b busy=%b required 1 0", done_seen, bus.busy);
        end
        next_cycle();
`endif
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.src_valid = 1'b0; bus.win_valid = 1'b0;
        test_reset();
        test_frame(0, 4, 0);
        test_frame(1, 4, 60);
        test_err();
        test_frame(2, 4, 0);
        test_reset_midframe();
        test_watchdog();
        test_frame(1, $urandom_range(2, 6), 70);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter FM_WIDTH, default 56: feature-map width/height in pixels (even, >=4).
REQ-002 SHALL have parameter PERIOD, default 8: minimum cycles between accepted pixel vectors (>=3).
REQ-003 SHALL have parameter PARAM_WORDS, default 64: parameter words written per layer load (2..128).
REQ-004 SHALL have parameter TIMEOUT, default 1024: stall limit in cycles, used only under WATCHDOG_EN.
REQ-005 SHALL have port clk, in, 1: single clock; one clock, all state on its rising edge.
REQ-006 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, in, 1: request to run one layer (parameter load followed by one frame).
REQ-008 SHALL have port src_valid, in, 1: upstream pixel vector available.
REQ-009 SHALL have port src_ready, out, 1: sequencer can accept a pixel vector this cycle.
REQ-010 SHALL have port pix_valid, out, 1: drives datapath data_in_valid.
REQ-011 SHALL have port vs_out, out, 1: drives datapath verticle_sync.
REQ-012 SHALL have port mode_out, out, 1: drives datapath mode_in (0 = load, 1 = calculate).
REQ-013 SHALL have port param_we, out, 1: parameter-memory write strobe.
REQ-014 SHALL have port param_addr, out, 7: parameter-memory word address.
REQ-015 SHALL have port win_valid, in, 1: datapath data_out_valid.
REQ-016 SHALL have port busy, out, 1: high in every state except IDLE.
REQ-017 SHALL have port frame_done, out, 1: one-cycle completion pulse.
REQ-018 SHALL have port win_count, out, 10: windows counted this frame, saturating at 1023.
REQ-019 SHALL have port err, out, 1: window-count mismatch flag.
REQ-020 SHALL have port timeout, out, 1: stall-abort flag.

Function
REQ-021 SHALL implement FSM IDLE->LOAD->VSYNC->STREAM->DRAIN->DONE->IDLE, one state register.
REQ-022 IDLE SHALL move to LOAD on start; start SHALL be ignored in every other state.
REQ-023 LOAD SHALL assert param_we for exactly PARAM_WORDS consecutive cycles, param_addr 0..PARAM_WORDS-1, then move to VSYNC.
REQ-024 VSYNC SHALL last exactly one cycle, with vs_out=1 and mode_out=1, then move to STREAM.
REQ-025 mode_out SHALL be 1 in VSYNC, STREAM, DRAIN and DONE, and 0 in IDLE and LOAD.
REQ-026 In STREAM, src_ready SHALL be 1 (combinational) when the gap counter is >= PERIOD-1; the first pixel is eligible in the first STREAM cycle.
REQ-027 pix_valid SHALL equal src_valid & src_ready, in the same cycle, with no register.
REQ-028 The gap counter SHALL clear on each accept, increment otherwise, and saturate at PERIOD-1.
REQ-029 The pixel counter SHALL count accepts; on accept FM_WIDTH*FM_WIDTH the FSM SHALL move to DRAIN.
REQ-030 DRAIN SHALL last 2*PERIOD cycles with src_ready=0, then move to DONE.
REQ-031 DONE SHALL last one cycle with frame_done=1, then move to IDLE.
REQ-032 win_count SHALL clear on VSYNC and increment on win_valid during STREAM or DRAIN, saturating at 1023.
REQ-033 err SHALL be set in DONE when win_count != (FM_WIDTH/2)^2, and cleared only at the next LOAD entry or by reset.
REQ-034 win_valid outside STREAM and DRAIN SHALL be ignored.

Reset
REQ-035 On rst=1, in any state including mid-frame, the FSM SHALL go to IDLE and all counters SHALL clear.
REQ-036 During and after reset, all outputs SHALL be 0: src_ready, pix_valid, vs_out, mode_out, param_we, param_addr, busy, frame_done, win_count, err, timeout.

Configuration
REQ-037 Macro WATCHDOG_EN defined: a stall counter SHALL count STREAM cycles with no accept and clear on each accept.
REQ-038 With WATCHDOG_EN defined, on count == TIMEOUT the FSM SHALL go to IDLE without a frame_done pulse, and timeout SHALL be set.
REQ-039 With WATCHDOG_EN defined, timeout SHALL stay set until the next start or reset.
REQ-040 Macro WATCHDOG_EN undefined: timeout SHALL be tied to 0, no stall counter SHALL exist, and STREAM SHALL wait indefinitely.

Verification (FM_WIDTH=4, PERIOD=8, PARAM_WORDS=4, TIMEOUT=64)
REQ-041 Start pulse -> param_we high 4 cycles with addr 0,1,2,3; then vs_out high exactly 1 cycle with mode_out=1.
REQ-042 src_valid held high -> 16 pix_valid pulses exactly 8 cycles apart; 16 cycles of DRAIN; frame_done 1 cycle; busy low the next cycle.
REQ-043 4 win_valid pulses injected -> win_count=4 and err=0 at DONE; 3 pulses -> err=1 at DONE, cleared on the next start.
REQ-044 rst asserted after the 7th accept -> next cycle all outputs 0; a new start runs a complete frame.
REQ-045 Start asserted during STREAM -> no effect; src_valid dropped for 20 cycles -> gap counter saturates and the pixel is accepted in the cycle src_valid returns.
REQ-046 WATCHDOG_EN defined, src_valid held low in STREAM -> after 64 cycles FSM in IDLE, timeout=1, frame_done never pulses; without WATCHDOG_EN -> busy stays 1.
